loopback_channel_emu: RTL
=========================

LOOPBACK_CHANNEL_EMU -- requirements
Module: loopback_channel_emu

Interface
REQ-001 Parameter DW, default 12: signed sample width of all I/Q ports and cfg_offset.
REQ-002 Parameter DELAY_DEPTH, default 16: delay-line length in clock cycles; power of two, at least 2.
REQ-003 Parameter NOISE_W, default 6: maximum noise magnitude width in bits; range 1..15.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; a value of 0 SHALL load 16'h0001.
REQ-005 Port clk_32M768, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-006 Port rst_32M768, input, 1 bit: reset, synchronous and active-high.
REQ-007 Ports in_I and in_Q, input, DW bits signed: transmit-side I/Q samples.
REQ-008 Port in_valid, input, 1 bit: samples are qualified; when low, the samples are treated as 0.
REQ-009 Port cfg_load, input, 1 bit: one-cycle pulse that latches all cfg_* inputs.
REQ-010 Port cfg_gain, input, 3 bits: gain numerator g; gain = g/4.
REQ-011 Port cfg_offset, input, DW bits signed: DC offset added to both rails.
REQ-012 Port cfg_noise_bits, input, 4 bits: noise width n; 0 disables noise; values above NOISE_W clamp to NOISE_W.
REQ-013 Port cfg_rot, input, 2 bits: phase rotation; 0 = none, 1 = -90 deg, 2 = 180 deg, 3 = +90 deg.
REQ-014 Port cfg_delay, input, log2(DELAY_DEPTH) bits: extra delay d in cycles.
REQ-015 Ports out_I and out_Q, output, DW bits signed: emulated receive-side samples.
REQ-016 Port out_valid, output, 1 bit: out_I and out_Q are qualified.
REQ-017 Port sat_count, output, 16 bits: count of saturated output samples.

Function
REQ-018 Stage 1 SHALL register in_I, in_Q and in_valid, replacing each sample with 0 when in_valid is low.
REQ-019 Stage 2 SHALL rotate the sample:
- rot 1: (Q, -I)
- rot 2: (-I, -Q)
- rot 3: (-Q, I)
- each negation is computed at DW+1 bits.
REQ-020 Stage 2 SHALL then apply gain as (x*g) >>> 2 (arithmetic shift, floor), at DW+4 bits.
REQ-021 Stage 3 SHALL add cfg_offset and an independent noise value to each rail:
- noise_I = LFSR[n-1:0]
- noise_Q = LFSR[15:16-n]
- both are unsigned, in the range 0..2^n-1.
REQ-022 Stage 3 SHALL saturate each rail to [-2^(DW-1), 2^(DW-1)-1].
REQ-023 Each stage-3 cycle with valid high in which either rail clipped SHALL increment sat_count, which holds at 16'hFFFF.
REQ-024 The LFSR SHALL be 16-bit Galois with polynomial x^16+x^14+x^13+x^11+1, advancing once per clock regardless of valid.
REQ-025 The delay line SHALL delay the stage-3 output (data and valid) by d further cycles.
REQ-026 Total latency from the in_valid edge sample to the out_valid edge SHALL be 3+d cycles; d = 0 gives 3 cycles.
REQ-027 Configuration SHALL be taken from the shadow registers only; cfg_* inputs SHALL be ignored except in a cycle with cfg_load high.
REQ-028 On cfg_load, the FSM SHALL go RUN -> FLUSH, with these actions:
- shadow registers updated
- delay line and stages 1-3 cleared (valid = 0)
- sat_count cleared.
REQ-029 In FLUSH, out_valid SHALL be 0 and a counter SHALL count 3+d cycles, after which the FSM returns to RUN.
REQ-030 Input samples accepted during FLUSH SHALL propagate normally, so the first valid output appears at exactly 3+d cycles after the load.
REQ-031 A cfg_load during FLUSH SHALL restart FLUSH with the new configuration.
REQ-032 A cfg_load in the same cycle as in_valid SHALL capture that sample into the cleared pipeline.

Reset
REQ-033 While rst_32M768 is high at a clock edge, the block SHALL reset to:
- out_I = 0, out_Q = 0, out_valid = 0, sat_count = 0
- pipeline and delay line cleared
- LFSR = seed
- FSM = RUN.
REQ-034 Shadow registers SHALL reset to: gain 4 (unity), offset 0, noise 0, rot 0, delay 0.
REQ-035 Reset asserted mid-operation SHALL override cfg_load and discard all in-flight samples.
REQ-036 The first valid output after reset release SHALL appear 3 cycles after the first in_valid.

Verification
REQ-037 Reset defaults, in_I=100, in_Q=-50, valid held -> out_valid rises 3 cycles later with out=(100,-50).
REQ-038 Load gain=3, offset=-16, noise 0, rot 0, d=5; in_I=1000 -> out_valid 8 cycles after load and after the input; out_I=734.
REQ-039 rot=1, gain=4, in=(2047,-2048) -> out=(-2048,-2047); rot=3 with in_Q=-2048 -> out_I=2047 saturated, sat_count=1.
REQ-040 gain=7, in_I=2000 -> out_I=2047; sat_count increments per valid sample; load pulse -> sat_count=0 and out_valid=0 for 3+d cycles.
REQ-041 noise_bits=5, zero input -> outputs in the range 0..31 and match a reference LFSR model every cycle; noise_bits=9 behaves as NOISE_W.
REQ-042 in_valid toggling 1,0,1 -> out_valid reproduces the pattern 3+d cycles later, with the gap sample out=offset+noise.

Source files
------------

// File: rtl/loopback_channel_emu.sv
// Baseband loopback channel emulator: rotation, gain, DC offset, LFSR noise,
// saturation and a programmable delay between a transmit and a receive I/Q stream.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  RUN   | normal operation, delayed stage-3 output is qualified
//  FLUSH | pipeline refilling after cfg_load, out_valid held low 3+d cycles
module loopback_channel_emu #(
    parameter int          DW          = 12,
    parameter int          DELAY_DEPTH = 16,
    parameter int          NOISE_W     = 6,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                           clk_32M768,
    input  logic                           rst_32M768,
    input  logic signed [DW-1:0]           in_I,
    input  logic signed [DW-1:0]           in_Q,
    input  logic                           in_valid,
    input  logic                           cfg_load,
    input  logic [2:0]                     cfg_gain,
    input  logic signed [DW-1:0]           cfg_offset,
    input  logic [3:0]                     cfg_noise_bits,
    input  logic [1:0]                     cfg_rot,
    input  logic [$clog2(DELAY_DEPTH)-1:0] cfg_delay,
    output logic signed [DW-1:0]           out_I,
    output logic signed [DW-1:0]           out_Q,
    output logic                           out_valid,
    output logic [15:0]                    sat_count
);

    localparam int AW = $clog2(DELAY_DEPTH);
    localparam int GW = DW + 4;
    localparam int SW = DW + 18;
    localparam logic [15:0]          SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [3:0]           NOISE_MAX = 4'(NOISE_W);
    localparam logic [AW:0]          CNT_ONE   = 1;
    localparam logic signed [SW-1:0] SAT_HI    = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO    = -SW'(2 ** (DW - 1));
    localparam logic signed [DW-1:0] OUT_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] OUT_MIN   = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t  state, state_nxt;
    logic [AW:0] flush_cnt, flush_cnt_nxt;
    logic [15:0] lfsr;

    logic [2:0]           sh_gain;
    logic signed [DW-1:0] sh_offset;
    logic [3:0]           sh_noise;
    logic [1:0]           sh_rot;
    logic [AW-1:0]        sh_delay;

    logic signed [DW-1:0] s1_i, s1_q, s3_i, s3_q;
    logic signed [GW-1:0] s2_i, s2_q;
    logic                 s1_v, s2_v, s3_v;

    logic signed [DW-1:0] dl_i [DELAY_DEPTH];
    logic signed [DW-1:0] dl_q [DELAY_DEPTH];
    logic                 dl_v [DELAY_DEPTH];
    logic [AW-1:0]        dsel;
    logic                 sel_v;

    logic signed [DW:0]   x_i, x_q, r_i, r_q;
    logic signed [GW-1:0] p_i, p_q, g_i, g_q;
    logic [15:0]          noise_mask, noise_i, noise_q;
    logic signed [SW-1:0] sum_i, sum_q;
    logic                 hi_i, lo_i, hi_q, lo_q;
    logic signed [DW-1:0] y_i, y_q;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (cfg_load) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = {1'b0, cfg_delay} + CNT_ONE;
        end else if (state == ST_FLUSH) begin
            if (flush_cnt == '0) state_nxt = ST_RUN;
            else                 flush_cnt_nxt = flush_cnt - CNT_ONE;
        end
    end

    // Rotation is done one bit wider so that negating the most negative input cannot wrap.
    always_comb begin
        x_i = {s1_i[DW-1], s1_i};
        x_q = {s1_q[DW-1], s1_q};
        r_i = x_i;
        r_q = x_q;
        case (sh_rot)
            2'd1:    begin r_i = x_q;  r_q = -x_i; end
            2'd2:    begin r_i = -x_i; r_q = -x_q; end
            2'd3:    begin r_i = -x_q; r_q = x_i;  end
            default: ;
        endcase
        p_i = $signed({{3{r_i[DW]}}, r_i}) * $signed({{(GW-3){1'b0}}, sh_gain});
        p_q = $signed({{3{r_q[DW]}}, r_q}) * $signed({{(GW-3){1'b0}}, sh_gain});
        g_i = p_i >>> 2;
        g_q = p_q >>> 2;
    end

    always_comb begin
        noise_mask = (16'd1 << sh_noise) - 16'd1;
        noise_i    = lfsr & noise_mask;
        noise_q    = lfsr >> (5'd16 - {1'b0, sh_noise});
        sum_i = $signed({{(SW-GW){s2_i[GW-1]}}, s2_i})
              + $signed({{(SW-DW){sh_offset[DW-1]}}, sh_offset})
              + $signed({{(SW-16){1'b0}}, noise_i});
        sum_q = $signed({{(SW-GW){s2_q[GW-1]}}, s2_q})
              + $signed({{(SW-DW){sh_offset[DW-1]}}, sh_offset})
              + $signed({{(SW-16){1'b0}}, noise_q});
        hi_i = sum_i > SAT_HI;
        lo_i = sum_i < SAT_LO;
        hi_q = sum_q > SAT_HI;
        lo_q = sum_q < SAT_LO;
        y_i  = hi_i ? OUT_MAX : (lo_i ? OUT_MIN : sum_i[DW-1:0]);
        y_q  = hi_q ? OUT_MAX : (lo_q ? OUT_MIN : sum_q[DW-1:0]);
    end

    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            lfsr      <= SEED;
            sh_gain   <= 3'd4;
            sh_offset <= '0;
            sh_noise  <= '0;
            sh_rot    <= '0;
            sh_delay  <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            lfsr      <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (cfg_load) begin
                sh_gain   <= cfg_gain;
                sh_offset <= cfg_offset;
                sh_noise  <= (cfg_noise_bits > NOISE_MAX) ? NOISE_MAX : cfg_noise_bits;
                sh_rot    <= cfg_rot;
                sh_delay  <= cfg_delay;
            end
        end
    end

    // Stage 1 always accepts the input so a sample arriving with cfg_load survives the flush.
    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            s1_v <= 1'b0; s1_i <= '0; s1_q <= '0;
            s2_v <= 1'b0; s2_i <= '0; s2_q <= '0;
            s3_v <= 1'b0; s3_i <= '0; s3_q <= '0;
            sat_count <= '0;
            for (int k = 0; k < DELAY_DEPTH; k++) begin
                dl_v[k] <= 1'b0; dl_i[k] <= '0; dl_q[k] <= '0;
            end
        end else begin
            s1_v <= in_valid;
            s1_i <= in_valid ? in_I : '0;
            s1_q <= in_valid ? in_Q : '0;
            if (cfg_load) begin
                s2_v <= 1'b0; s2_i <= '0; s2_q <= '0;
                s3_v <= 1'b0; s3_i <= '0; s3_q <= '0;
                sat_count <= '0;
                for (int k = 0; k < DELAY_DEPTH; k++) begin
                    dl_v[k] <= 1'b0; dl_i[k] <= '0; dl_q[k] <= '0;
                end
            end else begin
                s2_v <= s1_v; s2_i <= g_i; s2_q <= g_q;
                s3_v <= s2_v; s3_i <= y_i; s3_q <= y_q;
                dl_v[0] <= s3_v; dl_i[0] <= s3_i; dl_q[0] <= s3_q;
                for (int k = 1; k < DELAY_DEPTH; k++) begin
                    dl_v[k] <= dl_v[k-1]; dl_i[k] <= dl_i[k-1]; dl_q[k] <= dl_q[k-1];
                end
                if (s2_v && (hi_i || lo_i || hi_q || lo_q) && (sat_count != 16'hFFFF))
                    sat_count <= sat_count + 16'd1;
            end
        end
    end

    assign dsel = sh_delay - AW'(1);

    always_comb begin
        out_I = s3_i;
        out_Q = s3_q;
        sel_v = s3_v;
        if (sh_delay != '0) begin
            out_I = dl_i[dsel];
            out_Q = dl_q[dsel];
            sel_v = dl_v[dsel];
        end
        out_valid = sel_v && (state == ST_RUN);
    end

endmodule
